// File: rtl/mtl_avalon_cmd_master_if.sv
// Command stream, response pulse and Avalon-MM initiator signals of the MTL command master.
// The master modport is the initiator's view; slave is the view of whatever sits around it.
interface mtl_avalon_cmd_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              iCMD_valid;
  logic              oCMD_ready;
  logic              iCMD_write;
  logic [ADDR_W-1:0] iCMD_address;
  logic [DATA_W-1:0] iCMD_wdata;

  logic              oRSP_valid;
  logic [DATA_W-1:0] oRSP_rdata;
  logic              oRSP_timeout;
  logic              oBusy;

  logic [ADDR_W-1:0] oAvalon_address;
  logic              oAvalon_read;
  logic              oAvalon_write;
  logic [DATA_W-1:0] oAvalon_writedata;
  logic              iAvalon_waitrequest;
  logic [DATA_W-1:0] iAvalon_readdata;

  modport master (
    input  iCMD_valid, iCMD_write, iCMD_address, iCMD_wdata,
    input  iAvalon_waitrequest, iAvalon_readdata,
    output oCMD_ready, oRSP_valid, oRSP_rdata, oRSP_timeout, oBusy,
    output oAvalon_address, oAvalon_read, oAvalon_write, oAvalon_writedata
  );

  modport slave (
    output iCMD_valid, iCMD_write, iCMD_address, iCMD_wdata,
    output iAvalon_waitrequest, iAvalon_readdata,
    input  oCMD_ready, oRSP_valid, oRSP_rdata, oRSP_timeout, oBusy,
    input  oAvalon_address, oAvalon_read, oAvalon_write, oAvalon_writedata
  );
endinterface

// File: rtl/mtl_avalon_cmd_master.sv
// Avalon-MM initiator for the MTL register slave: buffers valid/ready commands in a FIFO and
// issues them one at a time, honouring waitrequest, fixed read latency and a stall timeout.
module mtl_avalon_cmd_master #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  mtl_avalon_cmd_master_if.master bus
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_RESP
  } state_t;

  logic              r_fifoWrite [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifoAddr  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoData  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_cmdReady;

  state_t            r_state;
  logic              r_isWrite;
  logic              r_avRead;
  logic              r_avWrite;
  logic [ADDR_W-1:0] r_avAddr;
  logic [DATA_W-1:0] r_avWdata;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [LAT_W-1:0]  r_latCnt;
  logic              r_rspValid;
  logic              r_rspTimeout;
  logic [DATA_W-1:0] r_rspRdata;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_countNext;
  logic              w_headWrite;
  logic [ADDR_W-1:0] w_headAddr;
  logic [DATA_W-1:0] w_headData;

  // Ready comes from a register so there is no combinational path from iCMD_valid.
  assign w_push      = bus.iCMD_valid & r_cmdReady;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_headWrite = r_fifoWrite[r_rdPtr];
  assign w_headAddr  = r_fifoAddr[r_rdPtr];
  assign w_headData  = r_fifoData[r_rdPtr];

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_fifoWrite[r_wrPtr] <= bus.iCMD_write;
      r_fifoAddr[r_wrPtr]  <= bus.iCMD_address;
      r_fifoData[r_wrPtr]  <= bus.iCMD_wdata;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_cmdReady <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count    <= w_countNext;
      r_cmdReady <= (w_countNext != CNT_W'(FIFO_DEPTH));
    end
  end

  // Bus strobes and response fields are registered straight out of the state machine.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= S_IDLE;
      r_isWrite    <= 1'b0;
      r_avRead     <= 1'b0;
      r_avWrite    <= 1'b0;
      r_avAddr     <= '0;
      r_avWdata    <= '0;
      r_waitCnt    <= '0;
      r_latCnt     <= '0;
      r_rspValid   <= 1'b0;
      r_rspTimeout <= 1'b0;
      r_rspRdata   <= '0;
    end else begin
      r_rspValid   <= 1'b0;
      r_rspTimeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_isWrite <= w_headWrite;
            r_avRead  <= ~w_headWrite;
            r_avWrite <= w_headWrite;
            r_avAddr  <= w_headAddr;
            r_avWdata <= w_headWrite ? w_headData : '0;
            r_waitCnt <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus.iAvalon_waitrequest) begin
            r_avRead  <= 1'b0;
            r_avWrite <= 1'b0;
            r_avAddr  <= '0;
            r_avWdata <= '0;
            r_waitCnt <= '0;
            if (r_isWrite) begin
              r_state <= S_IDLE;
            end else begin
              r_latCnt <= LAT_W'(1);
              r_state  <= S_RDWAIT;
            end
          end else if (r_waitCnt == WAIT_W'(TIMEOUT - 1)) begin
            // This edge is the TIMEOUT-th one seen with waitrequest high.
            r_avRead     <= 1'b0;
            r_avWrite    <= 1'b0;
            r_avAddr     <= '0;
            r_avWdata    <= '0;
            r_waitCnt    <= '0;
            r_rspValid   <= 1'b1;
            r_rspTimeout <= 1'b1;
            r_rspRdata   <= '0;
            r_state      <= S_RESP;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        S_RDWAIT: begin
          if (r_latCnt == LAT_W'(READ_LATENCY)) begin
            r_rspValid <= 1'b1;
            r_rspRdata <= bus.iAvalon_readdata;
            r_state    <= S_RESP;
          end else begin
            r_latCnt <= r_latCnt + LAT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oCMD_ready        = r_cmdReady;
  assign bus.oRSP_valid        = r_rspValid;
  assign bus.oRSP_rdata        = r_rspRdata;
  assign bus.oRSP_timeout      = r_rspTimeout;
  assign bus.oBusy             = (r_count != '0) || (r_state != S_IDLE);
  assign bus.oAvalon_address   = r_avAddr;
  assign bus.oAvalon_read      = r_avRead;
  assign bus.oAvalon_write     = r_avWrite;
  assign bus.oAvalon_writedata = r_avWdata;

endmodule

// File: tb/tb_mtl_avalon_cmd_master.sv
// Directed bench for mtl_avalon_cmd_master: a table of single transactions with a scripted
// slave, plus hand-written sequences for FIFO back-pressure and reset during a read.
module tb_mtl_avalon_cmd_master;

  logic clk;
  logic rst_n;

  mtl_avalon_cmd_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mtl_avalon_cmd_master #(
    .ADDR_W(8), .DATA_W(32), .READ_LATENCY(1), .FIFO_DEPTH(4), .TIMEOUT(255)
  ) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        isWrite;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waitCycles;
    logic [31:0] slaveData;
    int          expHigh;
    int          expRsp;
    logic [31:0] expRdata;
    logic        expTimeout;
  } vec_t;

  vec_t vecs[7];
  int   assertCount = 0;
  int   failCount   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One command through the DUT; the slave holds waitrequest for v.waitCycles strobe cycles
  // and presents slaveData only in the cycle where a LAT=1 read must sample it.
  task automatic applyStimulus(input vec_t v);
    int   high = 0;
    int   rsp = 0;
    int   badHold = 0;
    int   idleBad = 0;
    int   done = 0;
    logic acceptedRead = 1'b0;
    logic [31:0] gotRdata = '0;
    logic gotTimeout = 1'b0;
    @(negedge clk);
    checkOutput("vecReadyBefore", 32'(bus.oCMD_ready), 32'd1);
    bus.iCMD_valid          = 1'b1;
    bus.iCMD_write          = v.isWrite;
    bus.iCMD_address        = v.addr;
    bus.iCMD_wdata          = v.wdata;
    bus.iAvalon_waitrequest = 1'b1;
    @(negedge clk);
    bus.iCMD_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.iAvalon_readdata = acceptedRead ? v.slaveData : 32'hDEAD_BEEF;
      acceptedRead = 1'b0;
      if (!bus.oBusy) begin
        done = 1;
        break;
      end
      if (bus.oAvalon_read || bus.oAvalon_write) begin
        high++;
        if (bus.oAvalon_address !== v.addr || bus.oAvalon_write !== v.isWrite ||
            bus.oAvalon_read !== !v.isWrite || (v.isWrite && bus.oAvalon_writedata !== v.wdata))
          badHold++;
        bus.iAvalon_waitrequest = (high <= v.waitCycles);
        if (!bus.iAvalon_waitrequest && !v.isWrite) acceptedRead = 1'b1;
      end else begin
        if (bus.oAvalon_address !== 8'h00 || bus.oAvalon_writedata !== 32'h0) idleBad++;
      end
      if (bus.oRSP_valid) begin
        rsp++;
        gotRdata   = bus.oRSP_rdata;
        gotTimeout = bus.oRSP_timeout;
      end
      @(negedge clk);
    end
    checkOutput("vecDone", 32'(done), 32'd1);
    checkOutput("vecStrobeCycles", 32'(high), 32'(v.expHigh));
    checkOutput("vecHoldStable", 32'(badHold), 32'd0);
    checkOutput("vecIdleBusZero", 32'(idleBad), 32'd0);
    checkOutput("vecRspCount", 32'(rsp), 32'(v.expRsp));
    if (v.expRsp != 0) begin
      checkOutput("vecRspRdata", gotRdata, v.expRdata);
      checkOutput("vecRspTimeout", 32'(gotTimeout), 32'(v.expTimeout));
    end
  endtask

  initial begin
    int n;
    logic takeNow;
    logic [7:0]  gotAddr [6];
    logic [31:0] gotData [6];
    logic [7:0]  expAddr;
    logic [31:0] expData;
    int rspSeen;

    vecs[0] = '{1'b1, 8'h04, 32'h1234_5678, 0,    32'h0,         1,   0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 8'h08, 32'h0,         0,    32'hCAFE_F00D, 1,   1, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{1'b1, 8'h0C, 32'hA5A5_0001, 3,    32'h0,         4,   0, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 8'h33, 32'h0,         2,    32'h0BAD_C0DE, 3,   1, 32'h0BAD_C0DE, 1'b0};
    vecs[4] = '{1'b0, 8'h55, 32'h0,         1000, 32'h1111_2222, 255, 1, 32'h0,         1'b1};
    vecs[5] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 1000, 32'h0,         255, 1, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 8'h00, 32'h0,         0,    32'h0000_0001, 1,   1, 32'h0000_0001, 1'b0};

    rst_n                   = 1'b0;
    bus.iCMD_valid          = 1'b0;
    bus.iCMD_write          = 1'b0;
    bus.iCMD_address        = '0;
    bus.iCMD_wdata          = '0;
    bus.iAvalon_waitrequest = 1'b0;
    bus.iAvalon_readdata    = '0;

    #12;
    checkOutput("rstReady", 32'(bus.oCMD_ready), 32'd0);
    checkOutput("rstBusy", 32'(bus.oBusy), 32'd0);
    checkOutput("rstRead", 32'(bus.oAvalon_read), 32'd0);
    checkOutput("rstWrite", 32'(bus.oAvalon_write), 32'd0);
    checkOutput("rstRspValid", 32'(bus.oRSP_valid), 32'd0);
    checkOutput("rstRdata", bus.oRSP_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReadyAfter", 32'(bus.oCMD_ready), 32'd1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Occupy the FSM with a stalled write so the next five commands pile up in the FIFO.
    @(negedge clk);
    bus.iCMD_valid          = 1'b1;
    bus.iCMD_write          = 1'b1;
    bus.iCMD_address        = 8'h10;
    bus.iCMD_wdata          = 32'h0000_00A0;
    bus.iAvalon_waitrequest = 1'b1;
    @(negedge clk);
    bus.iCMD_valid = 1'b0;
    @(negedge clk);
    checkOutput("fifoStalledWrite", 32'(bus.oAvalon_write), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fifoReady%0d", i), 32'(bus.oCMD_ready), (i < 4) ? 32'd1 : 32'd0);
      bus.iCMD_valid   = 1'b1;
      bus.iCMD_address = 8'h20 + 8'(i);
      bus.iCMD_wdata   = 32'h0000_00B0 + 32'(i);
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("fifoFifthHeld", 32'(bus.oCMD_ready), 32'd0);
    checkOutput("fifoStallAddr", 32'(bus.oAvalon_address), 32'h10);

    bus.iAvalon_waitrequest = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      takeNow = bus.iCMD_valid && bus.oCMD_ready;
      if (bus.oAvalon_write) begin
        gotAddr[n] = bus.oAvalon_address;
        gotData[n] = bus.oAvalon_writedata;
        n++;
      end
      @(negedge clk);
      if (takeNow) bus.iCMD_valid = 1'b0;
    end
    checkOutput("fifoWriteCount", 32'(n), 32'd6);
    for (int i = 0; i < 6 && i < n; i++) begin
      expAddr = (i == 0) ? 8'h10 : 8'h20 + 8'(i - 1);
      expData = (i == 0) ? 32'hA0 : 32'hB0 + 32'(i - 1);
      checkOutput($sformatf("fifoOrderAddr%0d", i), 32'(gotAddr[i]), 32'(expAddr));
      checkOutput($sformatf("fifoOrderData%0d", i), gotData[i], expData);
    end
    for (int c = 0; c < 20 && bus.oBusy; c++) @(negedge clk);
    checkOutput("fifoDrained", 32'(bus.oBusy), 32'd0);

    // Reset while a read sits in RDWAIT: everything clears at once and no response follows.
    @(negedge clk);
    bus.iCMD_valid          = 1'b1;
    bus.iCMD_write          = 1'b0;
    bus.iCMD_address        = 8'h42;
    bus.iAvalon_waitrequest = 1'b0;
    bus.iAvalon_readdata    = 32'h7777_8888;
    @(negedge clk);
    bus.iCMD_valid = 1'b0;
    @(negedge clk);
    checkOutput("rdwRead", 32'(bus.oAvalon_read), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rdwRstRead", 32'(bus.oAvalon_read), 32'd0);
    checkOutput("rdwRstAddr", 32'(bus.oAvalon_address), 32'd0);
    checkOutput("rdwRstBusy", 32'(bus.oBusy), 32'd0);
    checkOutput("rdwRstReady", 32'(bus.oCMD_ready), 32'd0);
    checkOutput("rdwRstRdata", bus.oRSP_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rspSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.oRSP_valid) rspSeen++;
    end
    checkOutput("rdwNoRsp", 32'(rspSeen), 32'd0);
    checkOutput("rdwReadyAfter", 32'(bus.oCMD_ready), 32'd1);
    checkOutput("rdwBusyAfter", 32'(bus.oBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
